// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream multiplexer family.
// rr_pick is written against a fixed maximum width so future arbiters can share it.
package stream_mux_pkg;

  localparam int DATA_W    = 8;
  localparam int MAX_N     = 32;
  localparam int MAX_SEL_W = 5;

  typedef enum logic {ARB, LOCK} mux_state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_SEL_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid after ptr, wrapping at n (not at MAX_N).
  // ptr must be below n, so one subtraction is enough to wrap the candidate.
  function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0]     valid,
                                       input logic [MAX_SEL_W-1:0] ptr,
                                       input int                   n);
    rr_pick_t res;
    int       cand;
    res = '0;
    for (int k = 1; k <= MAX_N; k++) begin
      if (k <= n) begin
        cand = int'(ptr) + k;
        if (cand >= n) cand = cand - n;
        if (!res.found && valid[cand[MAX_SEL_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = cand[MAX_SEL_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus index of the winner.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N_IN  = 2,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_IN-1:0]  grant,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_N'(req), MAX_SEL_W'(ptr), N_IN);
    any   = pick.found;
    idx   = pick.idx[SEL_W-1:0];
    grant = '0;
    if (pick.found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream mux with round-robin arbitration and a registered output.
// Define MUX_PKT_LOCK_EN to hold the grant on one input until its packet's last beat.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_IN   = 2,
  parameter  int DATA_W = stream_mux_pkg::DATA_W,
  localparam int SEL_W  = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN-1:0]        in_valid,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [N_IN-1:0]        in_last,
  output logic [N_IN-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  output logic [SEL_W-1:0]       out_src,
  input  logic                   out_ready
);

  logic             load_en;
  logic             xfer;
  logic [N_IN-1:0]  req;
  logic [N_IN-1:0]  grant;
  logic [SEL_W-1:0] gidx;
  logic             any;
  logic [SEL_W-1:0] rr_ptr;

`ifdef MUX_PKT_LOCK_EN
  mux_state_e       state, state_nxt;
  logic [SEL_W-1:0] lock_src;

  // While locked only the owning input may compete, so the arbiter picks it or nobody.
  always_comb begin
    req = in_valid;
    if (state == LOCK) req = in_valid & (N_IN'(1) << lock_src);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      lock_src <= '0;
    end else begin
      state <= state_nxt;
      if (xfer && state == ARB && !in_last[gidx]) lock_src <= gidx;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:  if (xfer && !in_last[gidx]) state_nxt = LOCK;
      LOCK: if (xfer && in_last[gidx])  state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end
`else
  assign req = in_valid;
`endif

  rr_arbiter #(.N_IN(N_IN)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  assign load_en  = !out_valid || out_ready;
  assign xfer     = !rst && load_en && any;
  assign in_ready = (!rst && load_en) ? grant : '0;

  // Pointer follows the last winner; in lock mode that is always lock_src.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
      rr_ptr    <= SEL_W'(N_IN - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gidx*DATA_W +: DATA_W];
      out_last  <= in_last[gidx];
      out_src   <= gidx;
      rr_ptr    <= gidx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr with N_IN=4, DATA_W=8.
// Packet-lock expectations switch on MUX_PKT_LOCK_EN.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_src;
  logic        out_ready;

  int compared   = 0;
  int mismatched = 0;
  int acc [4]    = '{0, 0, 0, 0};

  stream_mux_rr #(.N_IN(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Per-source count of beats accepted downstream.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) acc[out_src] = acc[out_src] + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic ordy);
    in_valid  = v;
    in_last   = l;
    out_ready = ordy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Reset with every input requesting.
    rst = 1'b1;
    applyStimulus(4'hF, 4'hF, 1'b1);
    checkOutput("rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    tick();
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_src", 32'(out_src), 32'h0);
    checkOutput("rst_out_data", 32'(out_data), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_grant0", 32'(in_ready), 32'h1);
    tick();
    checkOutput("first_src", 32'(out_src), 32'h0);
    checkOutput("first_data", 32'(out_data), 32'hA0);
    checkOutput("first_valid", 32'(out_valid), 32'h1);

    // Full round-robin rotation, one beat per cycle.
    for (int k = 1; k <= 4; k++) begin
      checkOutput("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
      tick();
      checkOutput("rr_src", 32'(out_src), 32'(k % 4));
      checkOutput("rr_data", 32'(out_data), 32'hA0 + 32'(k % 4));
      checkOutput("rr_valid", 32'(out_valid), 32'h1);
    end

    // Backpressure: output holds src 0 beat.
    applyStimulus(4'hF, 4'hF, 1'b0);
    checkOutput("bp_in_ready", 32'(in_ready), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("bp_data", 32'(out_data), 32'hA0);
      checkOutput("bp_src", 32'(out_src), 32'h0);
      checkOutput("bp_valid", 32'(out_valid), 32'h1);
      checkOutput("bp_ready_low", 32'(in_ready), 32'h0);
    end
    applyStimulus(4'hF, 4'hF, 1'b1);
    tick();
    checkOutput("bp_rel_src1", 32'(out_src), 32'h1);
    tick();
    checkOutput("bp_rel_src2", 32'(out_src), 32'h2);
    applyStimulus(4'h0, 4'hF, 1'b1);
    tick();
    checkOutput("drain_valid", 32'(out_valid), 32'h0);
    checkOutput("drain_src_hold", 32'(out_src), 32'h2);
    checkOutput("drain_data_hold", 32'(out_data), 32'hA2);
    checkOutput("sb_src0", 32'(acc[0]), 32'd2);
    checkOutput("sb_src1", 32'(acc[1]), 32'd2);
    checkOutput("sb_src2", 32'(acc[2]), 32'd2);
    checkOutput("sb_src3", 32'(acc[3]), 32'd1);

    // Sparse: only input 2 requests, pointer must wrap back to it.
    applyStimulus(4'b0100, 4'hF, 1'b1);
    checkOutput("sparse_in_ready", 32'(in_ready), 32'h4);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("sparse_src", 32'(out_src), 32'h2);
      checkOutput("sparse_valid", 32'(out_valid), 32'h1);
      checkOutput("sparse_ready", 32'(in_ready), 32'h4);
    end
    applyStimulus(4'h0, 4'hF, 1'b1);
    checkOutput("drop_ready", 32'(in_ready), 32'h0);
    tick();
    checkOutput("sparse_drain", 32'(out_valid), 32'h0);

    // Packets: input 1 sends 3 beats while input 0 keeps requesting.
    applyStimulus(4'b0001, 4'hF, 1'b1);
    tick();
    checkOutput("pkt_pre_src0", 32'(out_src), 32'h0);
    applyStimulus(4'b0011, 4'b1101, 1'b1);
    checkOutput("pkt_grant1", 32'(in_ready), 32'h2);
    tick();
    checkOutput("pkt_a_src", 32'(out_src), 32'h1);
    checkOutput("pkt_a_last", 32'(out_last), 32'h0);
    tick();
`ifdef MUX_PKT_LOCK_EN
    checkOutput("pkt_b_src", 32'(out_src), 32'h1);
    checkOutput("pkt_b_last", 32'(out_last), 32'h0);
`else
    checkOutput("pkt_b_src", 32'(out_src), 32'h0);
    checkOutput("pkt_b_last", 32'(out_last), 32'h1);
`endif
    applyStimulus(4'b0011, 4'hF, 1'b1);
    tick();
    checkOutput("pkt_c_src", 32'(out_src), 32'h1);
    checkOutput("pkt_c_last", 32'(out_last), 32'h1);
    applyStimulus(4'b0001, 4'hF, 1'b1);
    tick();
    checkOutput("pkt_d_src", 32'(out_src), 32'h0);
    applyStimulus(4'h0, 4'hF, 1'b1);
    tick();
    checkOutput("pkt_drain", 32'(out_valid), 32'h0);

    // Reset in the middle of an input 1 packet.
    applyStimulus(4'b0010, 4'h0, 1'b1);
    tick();
    checkOutput("mid_b1_src", 32'(out_src), 32'h1);
    tick();
    checkOutput("mid_b2_src", 32'(out_src), 32'h1);
    rst = 1'b1;
    applyStimulus(4'b0011, 4'hF, 1'b1);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'h0);
    tick();
    checkOutput("mid_rst_valid", 32'(out_valid), 32'h0);
    checkOutput("mid_rst_src", 32'(out_src), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("mid_post_grant0", 32'(in_ready), 32'h1);
    tick();
    checkOutput("mid_post_src", 32'(out_src), 32'h0);
    checkOutput("mid_post_valid", 32'(out_valid), 32'h1);
    checkOutput("mid_next_grant1", 32'(in_ready), 32'h2);
    applyStimulus(4'h0, 4'hF, 1'b1);
    tick();

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
